// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcode, FSM state and shift-direction definitions for alu_seq
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      LSL = 3'b001,
      LSR = 3'b010,
      XOR = 3'b011,
      ADC = 3'b100,
      AND = 3'b101,
      SUB = 3'b110,
      CMP = 3'b111
   } alu_op_e;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } alu_state_e;

   localparam logic SHIFT_LEFT  = 1'b0;
   localparam logic SHIFT_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_bitshift.sv
// ============================================================================
// alu_bitshift : iterative one-bit-per-cycle shifter with down-counter
// Revision     : 1.0
// ============================================================================
`default_nettype none

module alu_bitshift
   import alu_seq_pkg::*;
#(
   parameter int W  = 9,
   parameter int CW = $clog2(W + 2)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          dir,
   input  logic [CW-1:0] amount,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  acc,
   output logic          out_bit,
   output logic          last
);

   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic [W-1:0]  shifted;

   // acc/out_bit present this cycle's step so the owner can retire on the final edge
   always_comb begin
      shifted = (dir_q == SHIFT_RIGHT) ? {1'b0, acc_q[W-1:1]} : {acc_q[W-2:0], 1'b0};
      out_bit = (dir_q == SHIFT_RIGHT) ? acc_q[0] : acc_q[W-1];
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      if (load) begin
         acc_d = din;
         cnt_d = amount;
         dir_d = dir;
      end else if (cnt_q != '0) begin
         acc_d = shifted;
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign acc  = shifted;
   assign last = (cnt_q == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
         dir_q <= SHIFT_LEFT;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         dir_q <= dir_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq  : multi-cycle ALU with start/busy/done handshake and carry register
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int W  = 9,
   parameter int CW = $clog2(W + 2)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [2:0]   alu_cmd,
   input  logic [W-1:0] inA,
   input  logic [W-1:0] inB,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] rslt,
   output logic         flag,
   output logic         zero,
   output logic         carry
);

   localparam logic [W-1:0] MAX_SHIFT = W'(W + 1);

   alu_state_e   state_q, state_d;
   logic [W-1:0] rslt_q, rslt_d;
   logic         flag_q, flag_d;
   logic         zero_q, zero_d;
   logic         carry_q, carry_d;
   logic         done_q, done_d;

   alu_op_e      op;
   logic [CW-1:0] shift_k;
   logic [W:0]   sum;
   logic [W:0]   diff;

   logic         sh_load;
   logic         sh_dir;
   logic [W-1:0] sh_acc;
   logic         sh_out;
   logic         sh_last;

   assign op      = alu_op_e'(alu_cmd);
   // Amounts beyond W+1 give the same all-zero result and zero flag as W+1
   assign shift_k = (inB >= MAX_SHIFT) ? CW'(W + 1) : inB[CW-1:0];
   assign sum     = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, (op == ADC) & carry_q};
   assign diff    = {1'b0, inA} - {1'b0, inB};

   alu_bitshift #(
      .W  (W),
      .CW (CW)
   ) u_bitshift (
      .clk     (clk),
      .reset   (reset),
      .load    (sh_load),
      .dir     (sh_dir),
      .amount  (shift_k),
      .din     (inA),
      .acc     (sh_acc),
      .out_bit (sh_out),
      .last    (sh_last)
   );

   always_comb begin
      state_d = state_q;
      rslt_d  = rslt_q;
      flag_d  = flag_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      done_d  = 1'b0;
      sh_load = 1'b0;
      sh_dir  = SHIFT_LEFT;
      case (state_q)
         IDLE: begin
            if (start) begin
               done_d = 1'b1;
               case (op)
                  ADD, ADC: begin
                     rslt_d  = sum[W-1:0];
                     flag_d  = sum[W];
                     carry_d = sum[W];
                  end
                  SUB: begin
                     rslt_d  = diff[W-1:0];
                     flag_d  = diff[W];
                     carry_d = diff[W];
                  end
                  XOR: begin
                     rslt_d = inA ^ inB;
                     flag_d = 1'b0;
                  end
                  AND: begin
                     rslt_d = inA & inB;
                     flag_d = 1'b0;
                  end
                  CMP: begin
                     rslt_d = '0;
                     flag_d = (inA == inB);
                  end
                  LSL, LSR: begin
                     if (shift_k == '0) begin
                        rslt_d = inA;
                        flag_d = 1'b0;
                     end else begin
                        done_d  = 1'b0;
                        sh_load = 1'b1;
                        sh_dir  = (op == LSR) ? SHIFT_RIGHT : SHIFT_LEFT;
                        state_d = SHIFT;
                     end
                  end
                  default: ;
               endcase
               if (op == CMP) begin
                  zero_d = (inA == inB);
               end else if (state_d == IDLE) begin
                  zero_d = (rslt_d == '0);
               end
            end
         end
         SHIFT: begin
            if (sh_last) begin
               rslt_d  = sh_acc;
               flag_d  = sh_out;
               zero_d  = (sh_acc == '0);
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rslt_q  <= '0;
         flag_q  <= 1'b0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rslt_q  <= rslt_d;
         flag_q  <= flag_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q == SHIFT);
   assign done  = done_q;
   assign rslt  = rslt_q;
   assign flag  = flag_q;
   assign zero  = zero_q;
   assign carry = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : directed vector-table bench for alu_seq (W=9 plus a W=16 instance)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;
   import alu_seq_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  alu_cmd;
   logic [8:0]  inA, inB;
   logic        busy, done, flag, zero, carry;
   logic [8:0]  rslt;

   logic        start16;
   logic [2:0]  cmd16;
   logic [15:0] a16, b16, rslt16;
   logic        busy16, done16, flag16, zero16, carry16;

   int checks;
   int failures;

   typedef struct {
      logic [2:0] cmd;
      logic [8:0] a;
      logic [8:0] b;
      logic [8:0] r;
      logic       f;
      logic       z;
      logic       c;
      int         lat;
   } vec_t;

   vec_t vecs[$];

   alu_seq #(.W(9)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .alu_cmd (alu_cmd),
      .inA     (inA),
      .inB     (inB),
      .busy    (busy),
      .done    (done),
      .rslt    (rslt),
      .flag    (flag),
      .zero    (zero),
      .carry   (carry)
   );

   alu_seq #(.W(16)) dut16 (
      .clk     (clk),
      .reset   (reset),
      .start   (start16),
      .alu_cmd (cmd16),
      .inA     (a16),
      .inB     (b16),
      .busy    (busy16),
      .done    (done16),
      .rslt    (rslt16),
      .flag    (flag16),
      .zero    (zero16),
      .carry   (carry16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [2:0] c, input logic [8:0] a, input logic [8:0] b,
                          input logic [8:0] r, input logic f, input logic z,
                          input logic cy, input int lat);
      vec_t v;
      v.cmd = c; v.a = a; v.b = b; v.r = r; v.f = f; v.z = z; v.c = cy; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Issues one op and waits for done; returns latency (0 on timeout) and busy-cycle count
   task automatic run_op(input logic [2:0] c, input logic [8:0] a, input logic [8:0] b,
                         output int lat, output int busy_cnt);
      @(negedge clk);
      start = 1'b1; alu_cmd = c; inA = a; inB = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      busy_cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busy_cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      int lat, bc, dcount;
      checks = 0;
      failures = 0;
      start16 = 1'b0; cmd16 = ADD; a16 = '0; b16 = '0;

      // Running carry after each op is tracked in the expected column
      add_vec(ADD, 9'h1FF, 9'h002, 9'h001, 1'b1, 1'b0, 1'b1, 1);
      add_vec(ADC, 9'h000, 9'h000, 9'h001, 1'b0, 1'b0, 1'b0, 1);
      add_vec(SUB, 9'h003, 9'h005, 9'h1FE, 1'b1, 1'b0, 1'b1, 1);
      add_vec(LSL, 9'h1FF, 9'h003, 9'h1F8, 1'b1, 1'b0, 1'b1, 4);
      add_vec(LSR, 9'h001, 9'h001, 9'h000, 1'b1, 1'b1, 1'b1, 2);
      add_vec(LSL, 9'h0A5, 9'h000, 9'h0A5, 1'b0, 1'b0, 1'b1, 1);
      add_vec(LSL, 9'h001, 9'h009, 9'h000, 1'b1, 1'b1, 1'b1, 10);
      add_vec(LSR, 9'h1FF, 9'h1FF, 9'h000, 1'b0, 1'b1, 1'b1, 11);
      add_vec(XOR, 9'h0F0, 9'h0FF, 9'h00F, 1'b0, 1'b0, 1'b1, 1);
      add_vec(AND, 9'h0F0, 9'h03C, 9'h030, 1'b0, 1'b0, 1'b1, 1);
      add_vec(CMP, 9'h055, 9'h055, 9'h000, 1'b1, 1'b1, 1'b1, 1);
      add_vec(CMP, 9'h055, 9'h054, 9'h000, 1'b0, 1'b0, 1'b1, 1);
      add_vec(ADC, 9'h1FF, 9'h000, 9'h000, 1'b1, 1'b1, 1'b1, 1);
      add_vec(ADD, 9'h100, 9'h0FF, 9'h1FF, 1'b0, 1'b0, 1'b0, 1);
      add_vec(LSR, 9'h100, 9'h008, 9'h001, 1'b0, 1'b0, 1'b0, 9);
      add_vec(XOR, 9'h0AA, 9'h0AA, 9'h000, 1'b0, 1'b1, 1'b0, 1);

      // Reset held with start asserted
      reset = 1'b1; start = 1'b1; alu_cmd = ADD; inA = 9'd5; inB = 9'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst%0d done", i), {31'd0, done}, 32'd0);
         chk($sformatf("rst%0d busy", i), {31'd0, busy}, 32'd0);
         chk($sformatf("rst%0d outs", i), {20'd0, rslt, flag, zero, carry}, 32'd0);
      end
      reset = 1'b0;
      start = 1'b0;
      run_op(ADD, 9'd5, 9'd7, lat, bc);
      chk("first rslt", {23'd0, rslt}, 32'd12);
      chk("first flag", {31'd0, flag}, 32'd0);
      chk("first lat", lat, 32'd1);

      foreach (vecs[i]) begin
         run_op(vecs[i].cmd, vecs[i].a, vecs[i].b, lat, bc);
         chk($sformatf("v%0d lat", i), lat, vecs[i].lat);
         chk($sformatf("v%0d busy", i), bc, vecs[i].lat - 1);
         chk($sformatf("v%0d rslt", i), {23'd0, rslt}, {23'd0, vecs[i].r});
         chk($sformatf("v%0d flag", i), {31'd0, flag}, {31'd0, vecs[i].f});
         chk($sformatf("v%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
         chk($sformatf("v%0d carry", i), {31'd0, carry}, {31'd0, vecs[i].c});
         @(negedge clk);
         chk($sformatf("v%0d done once", i), {31'd0, done}, 32'd0);
      end

      // Start held during a shift is ignored until the done cycle, then accepted
      @(negedge clk);
      start = 1'b1; alu_cmd = LSL; inA = 9'h1FF; inB = 9'd3;
      @(posedge clk);
      @(negedge clk);
      alu_cmd = XOR; inA = 9'h0F0; inB = 9'h0FF;
      dcount = 0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b2b busy%0d", i), {31'd0, busy}, 32'd1);
         if (done) dcount++;
         @(negedge clk);
      end
      chk("b2b early done", dcount, 32'd0);
      chk("b2b shift done", {31'd0, done}, 32'd1);
      chk("b2b shift busy", {31'd0, busy}, 32'd0);
      chk("b2b shift rslt", {23'd0, rslt}, 32'h1F8);
      chk("b2b shift flag", {31'd0, flag}, 32'd1);
      @(negedge clk);
      start = 1'b0;
      chk("b2b xor done", {31'd0, done}, 32'd1);
      chk("b2b xor rslt", {23'd0, rslt}, 32'h00F);
      chk("b2b xor flag", {31'd0, flag}, 32'd0);
      @(negedge clk);
      chk("b2b xor done once", {31'd0, done}, 32'd0);

      // Reset in the middle of a long shift
      @(negedge clk);
      start = 1'b1; alu_cmd = LSR; inA = 9'h1FF; inB = 9'h1FF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst busy", {31'd0, busy}, 32'd0);
      chk("midrst done", {31'd0, done}, 32'd0);
      chk("midrst outs", {20'd0, rslt, flag, zero, carry}, 32'd0);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      chk("midrst no done", dcount, 32'd0);

      run_op(CMP, 9'h055, 9'h055, lat, bc);
      chk("cmp lat", lat, 32'd1);
      chk("cmp rslt", {23'd0, rslt}, 32'd0);
      chk("cmp flag", {31'd0, flag}, 32'd1);
      chk("cmp zero", {31'd0, zero}, 32'd1);

      // Wider instance
      @(negedge clk);
      start16 = 1'b1; cmd16 = ADD; a16 = 16'hFFFF; b16 = 16'h0001;
      @(posedge clk);
      @(negedge clk);
      start16 = 1'b0;
      chk("w16 done", {31'd0, done16}, 32'd1);
      chk("w16 rslt", {16'd0, rslt16}, 32'd0);
      chk("w16 carry", {31'd0, carry16}, 32'd1);
      chk("w16 zero", {31'd0, zero16}, 32'd1);
      chk("w16 flag", {31'd0, flag16}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the 9-bit datapath ALU, keeping the same 3-bit opcode encoding.
- Adds a start/busy/done handshake and registered outputs.
- Adds an architectural carry register, consumed by a new ADC op.
- Shifts run iteratively, one bit per cycle.
- Sits between the register file and writeback; the control unit stalls on busy.

Parameters:
W, 9, datapath width in bits (>=2)
CW, $clog2(W+2), shift-counter width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
alu_cmd  input  3  opcode, sampled on accept
inA  input  W  operand A, sampled on accept
inB  input  W  operand B or shift amount, sampled on accept
busy  output  1  high while an op is in flight
done  output  1  one-cycle pulse; rslt/flag/zero valid
rslt  output  W  result; held until next completed op
flag  output  1  op-specific jump flag; held like rslt
zero  output  1  rslt==0 (CMP: operands equal); held
carry  output  1  architectural carry register

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset). Values after reset:
  - state=IDLE
  - busy=0, done=0, rslt=0, flag=0, zero=0, carry=0
  - Applies mid-operation too: any in-flight op is discarded and no done is issued.
- Accept: start=1 and state=IDLE at a rising edge. start while busy is ignored, with no queuing.
- Opcodes and results (all arithmetic modulo 2^W, unsigned):
  - 000 ADD: rslt=inA+inB; flag=carry-out; carry<=carry-out.
  - 001 LSL: rslt=inA<<n; flag=last bit shifted out.
  - 010 LSR: rslt=inA>>n, zero-fill; flag=last bit shifted out.
  - 011 XOR: rslt=inA^inB; flag=0.
  - 100 ADC: rslt=inA+inB+carry; flag=carry-out; carry<=carry-out.
  - 101 AND: rslt=inA&inB; flag=0.
  - 110 SUB: rslt=inA-inB; flag=borrow (inB>inA); carry<=borrow.
  - 111 CMP: rslt=0; flag=(inA==inB); zero=(inA==inB).
- carry is written only by ADD, ADC and SUB.
- zero=(rslt==0) for every op except CMP.
- Single-cycle ops (all except LSL/LSR):
  - Accept edge T → rslt/flag/zero/carry updated at edge T.
  - done=1 during cycle T+1; busy stays 0.
- Shift ops:
  - n = unsigned value of inB.
  - k = min(n, W+1); shift counter holds k.
  - FSM states: IDLE, SHIFT.
  - IDLE→SHIFT on accept when k>0; busy=1 from cycle T+1.
  - Each SHIFT cycle: shift the accumulator 1 bit, capture the outgoing bit into flag, decrement the counter.
  - When the counter reaches 0: rslt<=accumulator, state<=IDLE, done=1 for the following cycle. Total latency is k+1 cycles (accept to done).
- Shift boundary cases:
  - k=0: behaves as a single-cycle op with rslt=inA, flag=0.
  - n>=W+1: rslt=0, flag=0.
  - n=W: LSL flag=inA[0]; LSR flag=inA[W-1].
- Handshake and hold:
  - busy drops in the same cycle done pulses, so a new start may be accepted in the done cycle.
  - Outputs hold their values between ops; done never asserts twice for one op.

Decomposition:
- Package alu_seq_pkg contains:
  - alu_op_e: 3-bit enum ADD, LSL, LSR, XOR, ADC, AND, SUB, CMP, with the encodings above.
  - alu_state_e: IDLE, SHIFT.
- Sub-module alu_bitshift, parametrised by W:
  - Holds the accumulator, counter and direction.
  - Interface: load, dir, amount in; acc, out_bit, last out.
- alu_seq keeps the FSM, the single-cycle arithmetic and the carry register.

Test Plan:
- Reset hold: reset=1 for 3 cycles while start=1 with ADD 5+7 → outputs stay 0, no done. Release → the first accept completes with rslt=12, flag=0.
- Carry chain (W=9):
  - ADD 9'h1FF+9'h002 → rslt=9'h001, flag=1, carry=1.
  - Then ADC 9'h000+9'h000 → rslt=9'h001, carry=0.
  - Then SUB 3-5 → rslt=9'h1FE, flag=1, carry=1.
- Shift latency:
  - LSL inA=9'h1FF, inB=3 → busy for 3 cycles, done 4 cycles after accept, rslt=9'h1F8, flag=1.
  - LSR inA=9'h001, inB=1 → done after 2 cycles, rslt=0, flag=1, zero=1.
- Shift bounds:
  - LSL inB=0 → 1-cycle, rslt=inA, flag=0.
  - LSL inA=9'h001, inB=9 → rslt=0, flag=1.
  - LSR inB=9'h1FF → 11-cycle latency, rslt=0, flag=0.
- Busy/back-to-back:
  - start XOR while a shift is in flight → ignored.
  - start XOR 9'h0F0^9'h0FF asserted in the shift's done cycle → accepted; next cycle rslt=9'h00F, done=1.
- Mid-op reset and CMP:
  - Assert reset during SHIFT → IDLE next cycle, outputs 0, no done.
  - Then CMP 9'h055 vs 9'h055 → flag=1, zero=1, rslt=0.
  - Then re-run with parameter W=16: ADD 16'hFFFF+1 → rslt=0, carry=1, zero=1.
